spi_slave_rx: RTL



---
 rtl/spi_slave_rx_if.sv | 41 ++++
 rtl/spi_slave_rx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_if.sv
// Bundle of the SPI pins and the received-word handshake between the SPI slave
// receiver and its environment.
`timescale 1ns/1ps

interface spi_slave_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;
  logic                  overrun;
  logic                  frame_err;
  logic                  busy;

  modport slave (
    input  sclk,
    input  cs,
    input  mosi,
    input  data_ready,
    output data_out,
    output data_valid,
    output overrun,
    output frame_err,
    output busy
  );

  modport master (
    output sclk,
    output cs,
    output mosi,
    output data_ready,
    input  data_out,
    input  data_valid,
    input  overrun,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: oversamples sclk/cs/mosi in the clk domain and
// delivers MSB-first words on a valid/ready port with overrun and framing flags.
`timescale 1ns/1ps

module spi_slave_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  spi_slave_rx_if.slave bus
);

  localparam int                CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_csSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic                   r_sclkPrev;
  logic                   r_csPrev;

  logic [CNT_W-1:0]       r_bitCnt;
  // Only the low DATA_WIDTH-1 bits are kept; the oldest bit leaves straight into data_out.
  logic [DATA_WIDTH-2:0]  r_shiftReg;
  logic [DATA_WIDTH-1:0]  r_dataOut;
  logic                   r_dataValid;
  logic                   r_overrun;
  logic                   r_frameErr;

  logic                   w_sclk;
  logic                   w_cs;
  logic                   w_mosi;
  logic                   w_sclkRise;
  logic                   w_csRise;
  logic                   w_csFall;
  logic                   w_busy;
  logic                   w_bitStrobe;
  logic                   w_wordDone;
  logic                   w_frameAbort;
  logic [DATA_WIDTH-1:0]  w_shiftNext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclkSync <= '0;
      r_csSync   <= '0;
      r_mosiSync <= '0;
      r_sclkPrev <= 1'b0;
      r_csPrev   <= 1'b0;
    end else begin
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], bus.sclk};
      r_csSync   <= {r_csSync[SYNC_STAGES-2:0], bus.cs};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], bus.mosi};
      r_sclkPrev <= r_sclkSync[SYNC_STAGES-1];
      r_csPrev   <= r_csSync[SYNC_STAGES-1];
    end
  end

  assign w_sclk     = r_sclkSync[SYNC_STAGES-1];
  assign w_cs       = r_csSync[SYNC_STAGES-1];
  assign w_mosi     = r_mosiSync[SYNC_STAGES-1];
  assign w_sclkRise = w_sclk & ~r_sclkPrev;
  assign w_csRise   = w_cs & ~r_csPrev;
  assign w_csFall   = ~w_cs & r_csPrev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_csFall) w_nextState = SHIFT;
      SHIFT:   if (w_csRise) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // A cs rise outranks an sclk rise seen in the same cycle, so that bit is dropped.
  always_comb begin
    w_busy       = (r_state == SHIFT);
    w_bitStrobe  = (r_state == SHIFT) && w_sclkRise && !w_csRise;
    w_wordDone   = w_bitStrobe && (r_bitCnt == LAST_BIT);
    w_frameAbort = (r_state == SHIFT) && w_csRise && (r_bitCnt != '0);
    w_shiftNext  = {r_shiftReg, w_mosi};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitCnt    <= '0;
      r_shiftReg  <= '0;
      r_dataOut   <= '0;
      r_dataValid <= 1'b0;
      r_overrun   <= 1'b0;
      r_frameErr  <= 1'b0;
    end else begin
      r_overrun  <= 1'b0;
      r_frameErr <= w_frameAbort;

      if (r_state == IDLE) begin
        if (w_csFall) begin
          r_bitCnt   <= '0;
          r_shiftReg <= '0;
        end
      end else if (w_csRise) begin
        r_bitCnt <= '0;
      end else if (w_bitStrobe) begin
        r_shiftReg <= w_shiftNext[DATA_WIDTH-2:0];
        r_bitCnt   <= w_wordDone ? '0 : r_bitCnt + 1'b1;
      end

      if (w_wordDone) begin
        r_dataOut   <= w_shiftNext;
        r_dataValid <= 1'b1;
        r_overrun   <= r_dataValid & ~bus.data_ready;
      end else if (r_dataValid && bus.data_ready) begin
        r_dataValid <= 1'b0;
      end
    end
  end

  assign bus.data_out   = r_dataOut;
  assign bus.data_valid = r_dataValid;
  assign bus.overrun    = r_overrun;
  assign bus.frame_err  = r_frameErr;
  assign bus.busy       = w_busy;

endmodule
